pipelined_control_unit: RTL and testbench

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

---
 rtl/pipelined_control_unit_if.sv | 47 ++++
 rtl/pipelined_control_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_if.sv
// Decode-to-writeback control bus of the pipelined control unit.
// The master side drives decode fields, hazard controls and E-stage flags.
interface pipelined_control_unit_if #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned IMM_SRC_W  = 3
);
    logic [6:0]            Op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  StallE;
    logic                  FlushE;
    logic                  ZeroE;
    logic                  LtE;
    logic                  LtuE;

    logic [IMM_SRC_W-1:0]  ImmSrcD;
    logic                  RegWriteE;
    logic                  MemWriteE;
    logic                  ALUSrcE;
    logic                  JumpE;
    logic                  BranchE;
    logic                  JalrE;
    logic [1:0]            ALUSrcAE;
    logic [ALU_CTRL_W-1:0] ALUControlE;
    logic [1:0]            ResultSrcE;
    logic [1:0]            ResultSrcM;
    logic [1:0]            ResultSrcW;
    logic                  PCSrcE;
    logic                  RegWriteM;
    logic                  MemWriteM;
    logic                  RegWriteW;
    logic                  IllegalE;

    modport master (
        output Op, funct3, funct7, StallE, FlushE, ZeroE, LtE, LtuE,
        input  ImmSrcD, RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, JalrE,
        input  ALUSrcAE, ALUControlE, ResultSrcE, ResultSrcM, ResultSrcW,
        input  PCSrcE, RegWriteM, MemWriteM, RegWriteW, IllegalE
    );

    modport slave (
        input  Op, funct3, funct7, StallE, FlushE, ZeroE, LtE, LtuE,
        output ImmSrcD, RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, JalrE,
        output ALUSrcAE, ALUControlE, ResultSrcE, ResultSrcM, ResultSrcW,
        output PCSrcE, RegWriteM, MemWriteM, RegWriteW, IllegalE
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I pipelined control unit: combinational D decode, registered E/M/W controls.
// Optional macro PCU_ILLEGAL_DETECT_EN enables the registered IllegalE flag.
module pipelined_control_unit #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned IMM_SRC_W  = 3
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_control_unit_if.slave  bus
);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       alusrc;
        logic [1:0] alusrca;
        logic [3:0] alu;
        logic [1:0] resultsrc;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic [2:0] funct3;
    } ctrl_t;

    ctrl_t      ctrl_d, ctrl_q;
    logic [2:0] imm_src_d;
    logic       regwrite_m_q, memwrite_m_q, regwrite_w_q;
    logic [1:0] resultsrc_m_q, resultsrc_w_q;
    logic       taken;

    // funct7[5] picks SUB only for R-type; SRA/SRL split applies to both R and I forms.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
        logic [3:0] code;
        unique case (f3)
            3'b000:  code = (is_r && f7b5) ? AluSub : AluAdd;
            3'b001:  code = AluSll;
            3'b010:  code = AluSlt;
            3'b011:  code = AluSltu;
            3'b100:  code = AluXor;
            3'b101:  code = f7b5 ? AluSra : AluSrl;
            3'b110:  code = AluOr;
            3'b111:  code = AluAnd;
            default: code = AluAdd;
        endcase
        return code;
    endfunction

`ifdef PCU_ILLEGAL_DETECT_EN
    logic illegal_d, illegal_q;
`endif

    always_comb begin
        ctrl_d        = '0;
        ctrl_d.funct3 = bus.funct3;
        imm_src_d     = 3'd0;
`ifdef PCU_ILLEGAL_DETECT_EN
        illegal_d     = 1'b0;
`endif
        unique case (bus.Op)
            OpR: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alu      = alu_dec(bus.funct3, bus.funct7[5], 1'b1);
`ifdef PCU_ILLEGAL_DETECT_EN
                illegal_d = (bus.funct7 != 7'b0000000) && (bus.funct7 != 7'b0100000);
`endif
            end
            OpIAlu: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.alu      = alu_dec(bus.funct3, bus.funct7[5], 1'b0);
            end
            OpLoad: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.alusrc    = 1'b1;
                ctrl_d.resultsrc = 2'd1;
            end
            OpStore: begin
                ctrl_d.memwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                imm_src_d       = 3'd1;
            end
            OpBr: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu    = AluSub;
                imm_src_d     = 3'd2;
`ifdef PCU_ILLEGAL_DETECT_EN
                illegal_d = (bus.funct3[2:1] == 2'b01);
`endif
            end
            OpJal: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.jump      = 1'b1;
                ctrl_d.resultsrc = 2'd2;
                imm_src_d        = 3'd3;
            end
            OpJalr: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.jump      = 1'b1;
                ctrl_d.jalr      = 1'b1;
                ctrl_d.alusrc    = 1'b1;
                ctrl_d.resultsrc = 2'd2;
            end
            OpLui: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.alusrca  = 2'd2;
                imm_src_d       = 3'd4;
            end
            OpAuipc: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.alusrca  = 2'd1;
                imm_src_d       = 3'd4;
            end
            default: begin
                ctrl_d.funct3 = 3'd0;
`ifdef PCU_ILLEGAL_DETECT_EN
                illegal_d = 1'b1;
`endif
            end
        endcase
    end

    // Flush beats stall; a held E stage sends a bubble into M.
    always_ff @(posedge clk) begin
        if (!rst || bus.FlushE) begin
            ctrl_q <= '0;
        end else if (!bus.StallE) begin
            ctrl_q <= ctrl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || (bus.StallE && !bus.FlushE)) begin
            regwrite_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            resultsrc_m_q <= 2'd0;
        end else begin
            regwrite_m_q  <= ctrl_q.regwrite;
            memwrite_m_q  <= ctrl_q.memwrite;
            resultsrc_m_q <= ctrl_q.resultsrc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= 2'd0;
        end else begin
            regwrite_w_q  <= regwrite_m_q;
            resultsrc_w_q <= resultsrc_m_q;
        end
    end

`ifdef PCU_ILLEGAL_DETECT_EN
    always_ff @(posedge clk) begin
        if (!rst || bus.FlushE) begin
            illegal_q <= 1'b0;
        end else if (!bus.StallE) begin
            illegal_q <= illegal_d;
        end
    end
    assign bus.IllegalE = illegal_q;
`else
    logic unused_funct7;
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};
    assign bus.IllegalE  = 1'b0;
`endif

    always_comb begin
        unique case (ctrl_q.funct3)
            3'b000:  taken = bus.ZeroE;
            3'b001:  taken = !bus.ZeroE;
            3'b100:  taken = bus.LtE;
            3'b101:  taken = !bus.LtE;
            3'b110:  taken = bus.LtuE;
            3'b111:  taken = !bus.LtuE;
            default: taken = 1'b0;
        endcase
    end

    assign bus.PCSrcE      = ctrl_q.jump | (ctrl_q.branch & taken);
    assign bus.ImmSrcD     = IMM_SRC_W'(imm_src_d);
    assign bus.RegWriteE   = ctrl_q.regwrite;
    assign bus.MemWriteE   = ctrl_q.memwrite;
    assign bus.ALUSrcE     = ctrl_q.alusrc;
    assign bus.ALUSrcAE    = ctrl_q.alusrca;
    assign bus.ALUControlE = ALU_CTRL_W'(ctrl_q.alu);
    assign bus.ResultSrcE  = ctrl_q.resultsrc;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.JalrE       = ctrl_q.jalr;
    assign bus.RegWriteM   = regwrite_m_q;
    assign bus.MemWriteM   = memwrite_m_q;
    assign bus.ResultSrcM  = resultsrc_m_q;
    assign bus.RegWriteW   = regwrite_w_q;
    assign bus.ResultSrcW  = resultsrc_w_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode vector table plus hazard sequences.
module tb_pipelined_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

`ifdef PCU_ILLEGAL_DETECT_EN
    localparam logic IllEn = 1'b1;
`else
    localparam logic IllEn = 1'b0;
`endif

    pipelined_control_unit_if #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) bus ();

    pipelined_control_unit #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  imm;
        logic [13:0] ectl;
        logic        pcsrc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] mk(input logic rw, input logic mw, input logic as,
                                       input logic [1:0] asa, input logic [3:0] alu,
                                       input logic [1:0] rs, input logic j, input logic b,
                                       input logic jr);
        return {rw, mw, as, asa, alu, rs, j, b, jr};
    endfunction

    function automatic logic [13:0] e_bits();
        return {bus.RegWriteE, bus.MemWriteE, bus.ALUSrcE, bus.ALUSrcAE, bus.ALUControlE,
                bus.ResultSrcE, bus.JumpE, bus.BranchE, bus.JalrE};
    endfunction

    function automatic logic [21:0] all_regs();
        return {e_bits(), bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RegWriteW,
                bus.ResultSrcW, bus.IllegalE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.Op     = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
    endtask

    initial begin
        // op, funct3, funct7, ImmSrcD, {E controls}, PCSrcE (flags all 0)
        vecs.push_back('{7'b0110011, 3'b101, 7'b0100000, 3'd0, mk(1,0,0,0,9,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0110011, 3'b000, 7'b0100000, 3'd0, mk(1,0,0,0,1,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0110011, 3'b000, 7'b0000000, 3'd0, mk(1,0,0,0,0,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0110011, 3'b111, 7'b0000000, 3'd0, mk(1,0,0,0,2,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0110011, 3'b011, 7'b0000000, 3'd0, mk(1,0,0,0,6,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0110011, 3'b001, 7'b0000000, 3'd0, mk(1,0,0,0,7,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0010011, 3'b000, 7'b0100000, 3'd0, mk(1,0,1,0,0,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0010011, 3'b101, 7'b0100000, 3'd0, mk(1,0,1,0,9,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0010011, 3'b101, 7'b0000000, 3'd0, mk(1,0,1,0,8,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0010011, 3'b100, 7'b0000000, 3'd0, mk(1,0,1,0,4,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0010011, 3'b110, 7'b0000000, 3'd0, mk(1,0,1,0,3,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0010011, 3'b010, 7'b0000000, 3'd0, mk(1,0,1,0,5,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0000011, 3'b010, 7'b0000000, 3'd0, mk(1,0,1,0,0,1,0,0,0), 1'b0});
        vecs.push_back('{7'b0100011, 3'b010, 7'b0000000, 3'd1, mk(0,1,1,0,0,0,0,0,0), 1'b0});
        vecs.push_back('{7'b1100011, 3'b000, 7'b0000000, 3'd2, mk(0,0,0,0,1,0,0,1,0), 1'b0});
        vecs.push_back('{7'b1101111, 3'b000, 7'b0000000, 3'd3, mk(1,0,0,0,0,2,1,0,0), 1'b1});
        vecs.push_back('{7'b1100111, 3'b000, 7'b0000000, 3'd0, mk(1,0,1,0,0,2,1,0,1), 1'b1});
        vecs.push_back('{7'b0110111, 3'b000, 7'b0000000, 3'd4, mk(1,0,1,2,0,0,0,0,0), 1'b0});
        vecs.push_back('{7'b0010111, 3'b000, 7'b0000000, 3'd4, mk(1,0,1,1,0,0,0,0,0), 1'b0});
        vecs.push_back('{7'b1111111, 3'b000, 7'b0000000, 3'd0, mk(0,0,0,0,0,0,0,0,0), 1'b0});

        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        bus.ZeroE  = 1'b0;
        bus.LtE    = 1'b0;
        bus.LtuE   = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0000000);

        // Reset with an R-type in D
        rst = 1'b0;
        tick();
        check("reset_regs", 32'(all_regs()), 32'd0);
        check("reset_pcsrc", 32'(bus.PCSrcE), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
            #1;
            check($sformatf("vec%0d_immsrc", i), 32'(bus.ImmSrcD), 32'(vecs[i].imm));
            tick();
            check($sformatf("vec%0d_ectl", i), 32'(e_bits()), 32'(vecs[i].ectl));
            check($sformatf("vec%0d_pcsrc", i), 32'(bus.PCSrcE), 32'(vecs[i].pcsrc));
        end
        check("illegal_op_flag", 32'(bus.IllegalE), 32'(IllEn));
        check("illegal_op_regwrite", 32'(bus.RegWriteE), 32'd0);

        drive(7'b0110011, 3'b000, 7'b0000001);
        tick();
        check("illegal_f7_flag", 32'(bus.IllegalE), 32'(IllEn));

        // SRA through E, M, W
        drive(7'b0110011, 3'b101, 7'b0100000);
        tick();
        check("sra_alu", 32'(bus.ALUControlE), 32'd9);
        check("sra_rwe", 32'(bus.RegWriteE), 32'd1);
        drive(7'b1111111, 3'b000, 7'b0000000);
        tick();
        check("sra_rwm", 32'(bus.RegWriteM), 32'd1);
        tick();
        check("sra_rww", 32'(bus.RegWriteW), 32'd1);

        // Branch resolution in E
        drive(7'b1100011, 3'b001, 7'b0000000);
        tick();
        bus.ZeroE = 1'b0; #1;
        check("bne_taken", 32'(bus.PCSrcE), 32'd1);
        bus.ZeroE = 1'b1; #1;
        check("bne_not_taken", 32'(bus.PCSrcE), 32'd0);
        drive(7'b1100011, 3'b111, 7'b0000000);
        tick();
        bus.LtuE = 1'b0; #1;
        check("bgeu_taken", 32'(bus.PCSrcE), 32'd1);
        bus.LtuE = 1'b1; #1;
        check("bgeu_not_taken", 32'(bus.PCSrcE), 32'd0);
        drive(7'b1100011, 3'b100, 7'b0000000);
        tick();
        bus.LtE = 1'b1; #1;
        check("blt_taken", 32'(bus.PCSrcE), 32'd1);
        drive(7'b1100011, 3'b010, 7'b0000000);
        tick();
        check("br_f3_010_never", 32'(bus.PCSrcE), 32'd0);
        bus.ZeroE = 1'b0;
        bus.LtE   = 1'b0;
        bus.LtuE  = 1'b0;

        // Flush and stall together: flush wins
        drive(7'b1101111, 3'b000, 7'b0000000);
        tick();
        check("jal_pcsrc", 32'(bus.PCSrcE), 32'd1);
        drive(7'b0100011, 3'b010, 7'b0000000);
        bus.StallE = 1'b1;
        bus.FlushE = 1'b1;
        tick();
        check("flush_stall_ectl", 32'(e_bits()), 32'd0);
        check("flush_stall_pcsrc", 32'(bus.PCSrcE), 32'd0);
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;

        // Flush alone
        drive(7'b0000011, 3'b010, 7'b0000000);
        bus.FlushE = 1'b1;
        tick();
        check("flush_ectl", 32'(e_bits()), 32'd0);
        bus.FlushE = 1'b0;

        // LW held in E for two cycles
        drive(7'b0110011, 3'b000, 7'b0000000);
        tick();
        drive(7'b0000011, 3'b010, 7'b0000000);
        tick();
        check("lw_in_e_rs", 32'(bus.ResultSrcE), 32'd1);
        check("add_in_m_rw", 32'(bus.RegWriteM), 32'd1);
        drive(7'b0100011, 3'b010, 7'b0000000);
        bus.StallE = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("hold%0d_rse", c), 32'(bus.ResultSrcE), 32'd1);
            check($sformatf("hold%0d_rwe", c), 32'(bus.RegWriteE), 32'd1);
            check($sformatf("hold%0d_m", c),
                  32'({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM}), 32'd0);
        end
        bus.StallE = 1'b0;
        tick();
        check("release_lw_m", 32'({bus.RegWriteM, bus.ResultSrcM}), 32'b101);
        check("release_sw_e", 32'(bus.MemWriteE), 32'd1);
        check("release_w_bubble", 32'(bus.RegWriteW), 32'd0);

        // Reset overrides stall; decode stays live during reset
        drive(7'b0100011, 3'b010, 7'b0000000);
        bus.StallE = 1'b1;
        rst = 1'b0;
        tick();
        check("rst_over_stall", 32'(all_regs()), 32'd0);
        check("rst_over_stall_pc", 32'(bus.PCSrcE), 32'd0);
        check("rst_immsrc_live", 32'(bus.ImmSrcD), 32'd1);
        rst = 1'b1;
        bus.StallE = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
